// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and helpers for the stopwatch core:
//   - sw_state_e  : IDLE / RUN / PAUSE / DONE
//   - bcd_digit_t : one packed BCD digit
//   - SEC_MAX_TENS / SEC_MAX_ONES / DIGIT_MAX : per-digit rollover limits
//   - bcd_inc / bcd_dec : single-digit step returning digit plus carry/borrow
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t SEC_MAX_TENS = 4'd5;
    localparam bcd_digit_t SEC_MAX_ONES = 4'd9;
    localparam bcd_digit_t DIGIT_MAX    = 4'd9;

    typedef struct packed {
        logic       cy;
        bcd_digit_t d;
    } bcd_res_t;

    // Step one digit up; at (or beyond) its limit it wraps to 0 and carries.
    function automatic bcd_res_t bcd_inc(input bcd_digit_t d, input bcd_digit_t max);
        bcd_res_t r;
        if (d >= max) begin
            r.d  = '0;
            r.cy = 1'b1;
        end else begin
            r.d  = d + 4'd1;
            r.cy = 1'b0;
        end
        return r;
    endfunction

    // Step one digit down; from 0 it wraps to its limit and borrows.
    function automatic bcd_res_t bcd_dec(input bcd_digit_t d, input bcd_digit_t max);
        bcd_res_t r;
        if (d == '0) begin
            r.d  = max;
            r.cy = 1'b1;
        end else begin
            r.d  = d - 4'd1;
            r.cy = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_core_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Clock-enable strobe generator. Emits a one-cycle tick every DIV enabled
// cycles. restart_i forces the phase back to zero; while en_i is low the
// count is held so a resumed interval completes its remaining fraction.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   en_i       count enable (hold when low)
//   restart_i  synchronous phase restart (overrides en_i)
//   tick_o     strobe, high in the cycle the DIV-th enabled cycle is reached
// -----------------------------------------------------------------------------
module tick_gen
    import stopwatch_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
// Minutes:seconds up/down timer in packed BCD with paused field adjust,
// down-count expiry and optional lap capture.
// Optional feature macro: LAP_CAPTURE_EN (lap capture registers built only
// when defined; otherwise lap_bcd_o / lap_valid_o are tied low).
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_stop_i        pulse, toggles run/pause (starts from IDLE)
//   clear_i             pulse, back to IDLE and reload count
//   count_down_i        direction, latched on start from IDLE
//   preload_i           BCD reload value for down-count
//   adj_i, adj_sec_i    field adjust enable / select (seconds when 1)
//   lap_i               pulse, lap capture request
//   bcd_o               {minute digits..., sec_tens, sec_ones}
//   running_o           high in RUN
//   expired_o           high in DONE
//   wrap_o              one-cycle pulse on up-count rollover
//   lap_bcd_o           captured count
//   lap_valid_o         lap_bcd_o holds a capture
// -----------------------------------------------------------------------------
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter  int CLK_HZ     = 100_000_000,
    parameter  int ADJ_DIV    = 50_000_000,
    parameter  int MIN_DIGITS = 2,
    localparam int BW         = 4 * (MIN_DIGITS + 2)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_stop_i,
    input  logic          clear_i,
    input  logic          count_down_i,
    input  logic [BW-1:0] preload_i,
    input  logic          adj_i,
    input  logic          adj_sec_i,
    input  logic          lap_i,
    output logic [BW-1:0] bcd_o,
    output logic          running_o,
    output logic          expired_o,
    output logic          wrap_o,
    output logic [BW-1:0] lap_bcd_o,
    output logic          lap_valid_o
);

    localparam int ND = MIN_DIGITS + 2;

    // Digit 0 is sec_ones, digit 1 sec_tens, the rest are minute digits.
    function automatic bcd_digit_t digit_max(input int i);
        return (i == 0) ? SEC_MAX_ONES : (i == 1) ? SEC_MAX_TENS : DIGIT_MAX;
    endfunction

    // Full-count increment; MSB of the result is the rollover carry.
    function automatic logic [BW:0] count_up(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          cy;
        bcd_res_t      s;
        r  = v;
        cy = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (cy) begin
                s            = bcd_inc(v[4*i +: 4], digit_max(i));
                r[4*i +: 4]  = s.d;
                cy           = s.cy;
            end
        end
        return {cy, r};
    endfunction

    // Full-count decrement; never called on 00:00 (that state is DONE).
    function automatic logic [BW-1:0] count_dn(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          bw;
        bcd_res_t      s;
        r  = v;
        bw = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (bw) begin
                s            = bcd_dec(v[4*i +: 4], digit_max(i));
                r[4*i +: 4]  = s.d;
                bw           = s.cy;
            end
        end
        return r;
    endfunction

    // Seconds +1 mod 60, carry into minutes deliberately dropped.
    function automatic logic [BW-1:0] adj_seconds(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        bcd_res_t      lo;
        bcd_res_t      hi;
        r      = v;
        lo     = bcd_inc(v[3:0], SEC_MAX_ONES);
        hi     = bcd_inc(v[7:4], SEC_MAX_TENS);
        r[3:0] = lo.d;
        if (lo.cy) begin
            r[7:4] = hi.d;
        end
        return r;
    endfunction

    // Minutes +1 mod 10^MIN_DIGITS, seconds untouched.
    function automatic logic [BW-1:0] adj_minutes(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          cy;
        bcd_res_t      s;
        r  = v;
        cy = 1'b1;
        for (int i = 2; i < ND; i++) begin
            if (cy) begin
                s            = bcd_inc(v[4*i +: 4], DIGIT_MAX);
                r[4*i +: 4]  = s.d;
                cy           = s.cy;
            end
        end
        return r;
    endfunction

    sw_state_e     state_q, state_d;
    logic          dir_q, dir_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic          wrap_q, wrap_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;

    logic          sec_tick;
    logic          adj_tick;
    logic          sec_restart;
    logic          adj_win;
    logic          adj_restart;
    logic          run_tick;
    logic [BW:0]   up_res;
    logic [BW-1:0] dn_val;

    // The second divider runs only in RUN and restarts on clear or on a
    // fresh start from IDLE; resuming from PAUSE keeps the partial second.
    assign sec_restart = clear_i || ((state_q == IDLE) && start_stop_i);
    assign adj_win     = (state_q == IDLE) || (state_q == PAUSE);
    assign adj_restart = clear_i || !adj_win;

    tick_gen #(.DIV(CLK_HZ)) u_sec_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (state_q == RUN),
        .restart_i (sec_restart),
        .tick_o    (sec_tick)
    );

    tick_gen #(.DIV(ADJ_DIV)) u_adj_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (1'b1),
        .restart_i (adj_restart),
        .tick_o    (adj_tick)
    );

    // A tick coinciding with start_stop (or clear) loses to it.
    assign run_tick = (state_q == RUN) && !start_stop_i && sec_tick;
    assign up_res   = count_up(bcd_q);
    assign dn_val   = count_dn(bcd_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_stop_i) begin
                        state_d = (count_down_i && (bcd_q == '0)) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (start_stop_i) begin
                        state_d = PAUSE;
                    end else if (run_tick && dir_q && (dn_val == '0)) begin
                        state_d = DONE;
                    end
                end
                PAUSE: begin
                    if (start_stop_i) begin
                        state_d = RUN;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        dir_d  = dir_q;
        if (clear_i) begin
            bcd_d = count_down_i ? preload_i : '0;
        end else if ((state_q == IDLE) && start_stop_i) begin
            dir_d = count_down_i;
        end else if (run_tick) begin
            if (dir_q) begin
                bcd_d = dn_val;
            end else begin
                bcd_d  = up_res[BW-1:0];
                wrap_d = up_res[BW];
            end
        end else if (adj_win && adj_i && adj_tick && !start_stop_i) begin
            bcd_d = adj_sec_i ? adj_seconds(bcd_q) : adj_minutes(bcd_q);
        end
        running_d = (state_d == RUN);
        expired_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dir_q     <= 1'b0;
            bcd_q     <= '0;
            wrap_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            bcd_q     <= bcd_d;
            wrap_q    <= wrap_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign bcd_o     = bcd_q;
    assign running_o = running_q;
    assign expired_o = expired_q;
    assign wrap_o    = wrap_q;

`ifdef LAP_CAPTURE_EN
    logic [BW-1:0] lap_bcd_q;
    logic          lap_valid_q;

    // Captures the pre-tick count; the tick of the same cycle still applies.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lap_bcd_q   <= '0;
            lap_valid_q <= 1'b0;
        end else if (clear_i) begin
            lap_valid_q <= 1'b0;
        end else if ((state_q == RUN) && !start_stop_i && lap_i) begin
            lap_bcd_q   <= bcd_q;
            lap_valid_q <= 1'b1;
        end
    end

    assign lap_bcd_o   = lap_bcd_q;
    assign lap_valid_o = lap_valid_q;
`else
    assign lap_bcd_o   = '0;
    assign lap_valid_o = 1'b0 & lap_i;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

    localparam int CLK_HZ     = 10;
    localparam int ADJ_DIV    = 4;
    localparam int MIN_DIGITS = 2;
    localparam int BW         = 4 * (MIN_DIGITS + 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_stop = 1'b0;
    logic          clear = 1'b0;
    logic          count_down = 1'b0;
    logic [BW-1:0] preload = '0;
    logic          adj = 1'b0;
    logic          adj_sec = 1'b0;
    logic          lap = 1'b0;
    logic [BW-1:0] bcd;
    logic          running;
    logic          expired;
    logic          wrap;
    logic [BW-1:0] lap_bcd;
    logic          lap_valid;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_core #(
        .CLK_HZ     (CLK_HZ),
        .ADJ_DIV    (ADJ_DIV),
        .MIN_DIGITS (MIN_DIGITS)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_stop_i (start_stop),
        .clear_i      (clear),
        .count_down_i (count_down),
        .preload_i    (preload),
        .adj_i        (adj),
        .adj_sec_i    (adj_sec),
        .lap_i        (lap),
        .bcd_o        (bcd),
        .running_o    (running),
        .expired_o    (expired),
        .wrap_o       (wrap),
        .lap_bcd_o    (lap_bcd),
        .lap_valid_o  (lap_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_bcd", bcd, 16'h0000);
        check("rst_running", running, 1'b0);
        check("rst_expired", expired, 1'b0);
        check("rst_wrap", wrap, 1'b0);
        check("rst_lap_bcd", lap_bcd, 16'h0000);
        check("rst_lap_valid", lap_valid, 1'b0);

        // Up count: first tick 10 edges after the start edge
        pulse_start();
        step(9);
        check("up_before_tick", bcd, 16'h0000);
        step(1);
        check("up_first_tick", bcd, 16'h0001);
        check("up_running", running, 1'b1);
        step(60);
        check("up_0007", bcd, 16'h0007);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
`ifdef LAP_CAPTURE_EN
        check("lap_bcd_0007", lap_bcd, 16'h0007);
        check("lap_valid_set", lap_valid, 1'b1);
`else
        check("lap_bcd_off", lap_bcd, 16'h0000);
        check("lap_valid_off", lap_valid, 1'b0);
`endif
        step(528);
        check("up_0059", bcd, 16'h0059);
        step(1);
        check("up_0100", bcd, 16'h0100);

        // Clear, then pause/resume in the middle of a second
        pulse_clear();
        check("clr_bcd", bcd, 16'h0000);
        check("clr_running", running, 1'b0);
        check("clr_lap_valid", lap_valid, 1'b0);
        pulse_start();
        step(4);
        pulse_start();
        check("pause_running", running, 1'b0);
        step(29);
        check("pause_frozen", bcd, 16'h0000);
        pulse_start();
        check("resume_running", running, 1'b1);
        step(4);
        check("resume_pre_tick", bcd, 16'h0000);
        step(1);
        check("resume_tick", bcd, 16'h0001);

        // Adjust in PAUSE, one adjust tick every 4 cycles
        pulse_start();
        check("adj_paused", running, 1'b0);
        adj = 1'b1;
        adj_sec = 1'b0;
        step(4 * 99);
        check("adj_min_99", bcd, 16'h9901);
        step(4);
        check("adj_min_wrap", bcd, 16'h0001);
        step(4 * 99);
        check("adj_min_99b", bcd, 16'h9901);
        adj_sec = 1'b1;
        step(4 * 58);
        check("adj_sec_59", bcd, 16'h9959);
        step(4);
        check("adj_sec_wrap", bcd, 16'h9900);
        step(4 * 58);
        check("adj_sec_58", bcd, 16'h9958);
        adj = 1'b0;

        // Resume from 99:58 and roll over; divider held 1 count in PAUSE
        pulse_start();
        check("roll_running", running, 1'b1);
        step(8);
        check("roll_hold", bcd, 16'h9958);
        step(1);
        check("roll_9959", bcd, 16'h9959);
        check("roll_no_wrap", wrap, 1'b0);
        step(9);
        check("roll_9959_hold", bcd, 16'h9959);
        step(1);
        check("roll_0000", bcd, 16'h0000);
        check("roll_wrap", wrap, 1'b1);
        check("roll_still_running", running, 1'b1);
        step(1);
        check("roll_wrap_one_cycle", wrap, 1'b0);
        step(9);
        check("roll_after", bcd, 16'h0001);

        // Down count from 00:02 to expiry
        count_down = 1'b1;
        preload = 16'h0002;
        pulse_clear();
        check("dn_preload", bcd, 16'h0002);
        pulse_start();
        count_down = 1'b0;
        step(9);
        check("dn_hold", bcd, 16'h0002);
        step(1);
        check("dn_0001", bcd, 16'h0001);
        check("dn_not_expired", expired, 1'b0);
        step(10);
        check("dn_0000", bcd, 16'h0000);
        check("dn_expired", expired, 1'b1);
        check("dn_running", running, 1'b0);
        pulse_start();
        check("done_ss_bcd", bcd, 16'h0000);
        check("done_ss_expired", expired, 1'b1);
        check("done_ss_running", running, 1'b0);
        adj = 1'b1;
        adj_sec = 1'b1;
        step(12);
        adj = 1'b0;
        check("done_adj_bcd", bcd, 16'h0000);

        // Down start with zero count expires immediately
        count_down = 1'b1;
        preload = 16'h0000;
        pulse_clear();
        check("zero_clr_expired", expired, 1'b0);
        pulse_start();
        check("zero_start_expired", expired, 1'b1);
        check("zero_start_running", running, 1'b0);

        // clear and start_stop together: clear wins
        preload = 16'h0003;
        clear = 1'b1;
        start_stop = 1'b1;
        step(1);
        clear = 1'b0;
        start_stop = 1'b0;
        check("both_bcd", bcd, 16'h0003);
        check("both_expired", expired, 1'b0);
        check("both_running", running, 1'b0);
        step(12);
        check("both_idle_bcd", bcd, 16'h0003);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check("lap_idle_ignored", lap_valid, 1'b0);
        count_down = 1'b0;
        pulse_clear();
        check("final_clr", bcd, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Parametrised single-clock minutes:seconds timer core; successor to the board-level stopwatch. It counts up or down in packed BCD and supports a paused field-adjust mode, a down-count expiry flag and optional lap capture. Its inputs are already-debounced single-cycle button pulses. It drives a separate seven-segment scanner through its BCD output, and uses clock-enable strobes from one divider instead of derived clocks.

## Interface
- CLK_HZ, 100_000_000: input clock frequency; one count tick every CLK_HZ cycles.
- ADJ_DIV, 50_000_000: cycles per adjust tick (2 Hz at default).
- MIN_DIGITS, 2: BCD minute digits (1..3); minutes max 10^MIN_DIGITS-1.
- BW, 4*(MIN_DIGITS+2): derived BCD width (localparam).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_stop  in  1  1-cycle pulse; toggles run/pause.
- clear  in  1  1-cycle pulse; returns to IDLE and reloads count.
- count_down  in  1  direction; sampled only in IDLE.
- preload  in  BW  BCD start value for down-count; must be valid BCD, seconds <60.
- adj  in  1  level; enables field adjust in IDLE/PAUSE.
- adj_sec  in  1  level; 1 = adjust seconds, 0 = adjust minutes.
- lap  in  1  1-cycle pulse; capture request.
- bcd  out  BW  current count {minutes..., sec_tens, sec_ones}.
- running  out  1  high in RUN.
- expired  out  1  high in DONE.
- wrap  out  1  1-cycle pulse on up-count rollover.
- lap_bcd  out  BW  captured count.
- lap_valid  out  1  lap_bcd holds a capture.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset -> IDLE.
- Reset values: bcd=0, running=0, expired=0, wrap=0, lap_bcd=0, lap_valid=0. The direction register resets to up.
- Input priority per cycle: rst > clear > start_stop > lap > count/adjust tick.
- clear, from any state -> IDLE:
  - bcd = 0 if count_down=0, else bcd = preload.
  - lap_valid=0.
  - Both tick dividers restart.
- IDLE + start_stop:
  - count_down is latched as the direction.
  - -> RUN, and the second divider restarts.
  - Down mode with bcd=0: -> DONE immediately.
- RUN + start_stop -> PAUSE. PAUSE + start_stop -> RUN; the divider is not restarted.
- DONE ignores start_stop and adj. Only clear or rst leave DONE.
- RUN, on each second tick:
  - Up: increment with BCD carry; sec_ones 9->0, sec_tens 5->0, then minutes carry.
  - Up at max (99:59 for MIN_DIGITS=2): -> 00:00, wrap=1 for one cycle, keep running.
  - Down: decrement with borrow. Reaching 00:00 -> DONE the same cycle; expired=1, running=0.
- Adjust, active only when adj=1 and state is IDLE or PAUSE, on each adjust tick:
  - adj_sec=1: seconds +1 mod 60, no carry into minutes.
  - adj_sec=0: minutes +1 mod 10^MIN_DIGITS; seconds unchanged.
  - adj is ignored in RUN.
- lap in RUN (LAP_CAPTURE_EN only): lap_bcd = bcd pre-tick value of that cycle, lap_valid=1. lap in other states is ignored.

## Timing
- All outputs are registered. bcd changes on the cycle after the tick strobe.
- The first second tick after start occurs CLK_HZ cycles after the start_stop cycle.
- In PAUSE the divider holds its value. Resuming completes the remaining fraction of the second.
- The adjust divider free-runs in IDLE/PAUSE and is held at 0 elsewhere.
- expired rises together with bcd=0.

## Configuration
- LAP_CAPTURE_EN defined: lap capture logic as above.
- Not defined: lap is ignored; lap_bcd and lap_valid are tied to 0; no capture registers are built.

## Structure
- stopwatch_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - bcd_digit_t (4-bit);
  - SEC_MAX_TENS=5 and SEC_MAX_ONES=9 constants;
  - BCD increment/decrement functions returning digit plus carry/borrow.
- One sub-module, tick_gen: parametrised divider with enable and sync restart. It emits a 1-cycle strobe every DIV cycles and is instantiated twice (second, adjust).

## Test plan
- CLK_HZ=10, up count: rst, then start_stop. Expect bcd 00:01 at cycle 11 and 01:00 after 600 cycles.
- Up-count rollover: from preset 99:58 (via adjust), run 20 cycles. Expect 99:59, then 00:00 with a single wrap pulse; running stays 1.
- Down count: count_down=1, preload=00:02, clear, start. Expect 00:01, then 00:00 with expired=1, running=0. A further start_stop leaves the state unchanged.
- Pause/resume mid-second: start_stop at cycle 5, pause 30 cycles, resume. Expect the next tick 5 cycles later; bcd is frozen during pause.
- Adjust in PAUSE: adj=1, adj_sec=1, seconds at 59, one adjust tick. Expect seconds 00 with minutes unchanged. With adj_sec=0 and minutes 99, expect minutes 00.
- Same-cycle clear+start_stop: expect IDLE with bcd reloaded. With LAP_CAPTURE_EN, lap at 00:07 gives lap_bcd=00:07 and lap_valid=1, and clear drops lap_valid.
